// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, flag bit positions
// and format helpers parameterised on exponent/fraction width.
package fp_pkg;

    typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_e;

    // flags = {invalid, overflow, underflow, inexact}
    localparam int FLG_W  = 4;
    localparam int FLG_NV = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // sign 0, exponent all ones, fraction MSB set, rest clear
    function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'd1 << (man_w - 1));
        return r;
    endfunction

    function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic frac_zero, input logic frac_msb);
        if (exp_ones)       return frac_zero ? INF : (frac_msb ? QNAN : SNAN);
        else if (exp_zero)  return frac_zero ? ZERO : SUB;
        else                return NORM;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
    parameter int WIDTH = 27,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CW-1:0]    cnt
);

    // scan upward so the highest set bit has the last word
    always_comb begin
        cnt = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++)
            if (din[i]) cnt = CW'(WIDTH - 1 - i);
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE 754 adder/subtractor, round-to-nearest-even.
// S1 unpack/classify/align, S2 add/normalise, S3 round/pack.
// Define FP_ADDSUB_SUBNORMAL_EN for gradual underflow; otherwise
// subnormal inputs are flushed to signed zero and tiny results to zero.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic [FLG_W-1:0] flags
);

    localparam int STAGES = 3;
    localparam int SW     = MAN_W + 4;          // hidden + fraction + G/R/S
    localparam int XW     = EXP_W + 2;          // exponent with headroom
    localparam int LZW    = $clog2(SW + 1);
    localparam int EMAX   = (1 << EXP_W) - 1;
    localparam logic [W-1:0] CNAN = W'(fp_canon_nan(EXP_W, MAN_W));

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SW-1:0]    sig_x;
        logic [SW-1:0]    sig_y;
        logic             eff_sub;
        logic             zero_sign;
        logic             spec;
        logic [W-1:0]     spec_res;
        logic [FLG_W-1:0] spec_flg;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic [XW-1:0]    exp;
        logic [SW-1:0]    norm;
        logic             tiny;
        logic             zero;
        logic             spec;
        logic [W-1:0]     spec_res;
        logic [FLG_W-1:0] spec_flg;
    } s2_t;

    logic [STAGES:1] vld_pipe;
    logic            adv;
    s1_t             s1_d, r1;
    s2_t             s2_d, r2;

    assign out_valid = vld_pipe[STAGES];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic             sa, sb, swap, hx, hy, nan_a, nan_b, inf_inf;
    logic [EXP_W-1:0] ea, eb, ex_raw, ey_raw, exx, eyy, d;
    logic [MAN_W-1:0] fa, fb, fx, fy;
    fp_class_e        ca, cb;
    logic [31:0]      sh;
    logic [2*SW-1:0]  ext;

    // classify operands, order by magnitude and right-align the smaller one
    always_comb begin
        sa = a[W-1];
        ea = a[W-2:MAN_W];
        fa = a[MAN_W-1:0];
        sb = b[W-1] ^ sub;
        eb = b[W-2:MAN_W];
        fb = b[MAN_W-1:0];
        ca = fp_classify(ea == '0, &ea, fa == '0, fa[MAN_W-1]);
        cb = fp_classify(eb == '0, &eb, fb == '0, fb[MAN_W-1]);
`ifndef FP_ADDSUB_SUBNORMAL_EN
        if (ca == SUB) begin fa = '0; ca = ZERO; end
        if (cb == SUB) begin fb = '0; cb = ZERO; end
`endif
        // raw {exp,frac} orders magnitudes correctly, subnormals included
        swap   = {eb, fb} > {ea, fa};
        ex_raw = swap ? eb : ea;
        ey_raw = swap ? ea : eb;
        fx     = swap ? fb : fa;
        fy     = swap ? fa : fb;
        hx     = ex_raw != '0;
        hy     = ey_raw != '0;
        exx    = hx ? ex_raw : EXP_W'(1);
        eyy    = hy ? ey_raw : EXP_W'(1);
        d      = exx - eyy;
        sh     = (32'(d) > 32'(MAN_W + 3)) ? 32'(MAN_W + 3) : 32'(d);
        ext    = {hy, fy, 3'b000, {SW{1'b0}}} >> sh;

        s1_d           = '0;
        s1_d.sign      = swap ? sb : sa;
        s1_d.exp       = exx;
        s1_d.sig_x     = {hx, fx, 3'b000};
        s1_d.sig_y     = ext[2*SW-1:SW] | SW'(|ext[SW-1:0]);
        s1_d.eff_sub   = sa ^ sb;
        // exact zero is +0 unless both operands carry a minus sign
        s1_d.zero_sign = (sa ^ sb) ? 1'b0 : sa;

        nan_a   = (ca == QNAN) || (ca == SNAN);
        nan_b   = (cb == QNAN) || (cb == SNAN);
        inf_inf = (ca == INF) && (cb == INF) && (sa != sb);
        s1_d.spec = nan_a || nan_b || (ca == INF) || (cb == INF);
        if (nan_a || nan_b || inf_inf) begin
            s1_d.spec_res         = CNAN;
            s1_d.spec_flg[FLG_NV] = (ca == SNAN) || (cb == SNAN) || inf_inf;
        end else if (ca == INF) begin
            s1_d.spec_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            s1_d.spec_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // ---------------- S2: add/subtract, normalise ----------------
    logic [SW:0]    sum;
    logic [LZW-1:0] lz;
    logic [XW-1:0]  ex, lim, lzx, sh2;

    fp_lzc #(.WIDTH(SW)) u_lzc (
        .din (sum[SW-1:0]),
        .cnt (lz)
    );

    // X >= Y by construction, so the difference never goes negative and the
    // exponent never drops below 1; the extra exponent bits absorb carries
    always_comb begin
        sum = r1.eff_sub ? ({1'b0, r1.sig_x} - {1'b0, r1.sig_y})
                         : ({1'b0, r1.sig_x} + {1'b0, r1.sig_y});
        ex  = XW'(r1.exp);
        lim = ex - XW'(1);
        lzx = XW'(lz);
        sh2 = (lzx > lim) ? lim : lzx;

        s2_d          = '0;
        s2_d.spec     = r1.spec;
        s2_d.spec_res = r1.spec_res;
        s2_d.spec_flg = r1.spec_flg;
        s2_d.zero     = sum == '0;
        s2_d.sign     = s2_d.zero ? r1.zero_sign : r1.sign;
        if (sum[SW]) begin
            s2_d.norm = sum[SW:1] | SW'(sum[0]);
            s2_d.exp  = ex + XW'(1);
        end else begin
            s2_d.norm = sum[SW-1:0] << sh2;
            s2_d.exp  = ex - sh2;
        end
        // shift was clamped before the hidden bit reached the top: subnormal
        s2_d.tiny = !s2_d.norm[SW-1] && !s2_d.zero;
    end

    // ---------------- S3: round, pack, flags ----------------
    logic [MAN_W:0]   mant;
    logic [MAN_W+1:0] rnd;
    logic             g, r, s, nx, up;
    logic [XW-1:0]    exp_f;
    logic [W-1:0]     res;
    logic [FLG_W-1:0] flg;

    // RNE on G/R/S, then pick special, zero, overflow, tiny or normal result
    always_comb begin
        mant  = r2.norm[SW-1:3];
        g     = r2.norm[2];
        r     = r2.norm[1];
        s     = r2.norm[0];
        nx    = g | r | s;
        up    = g & (r | s | mant[0]);
        rnd   = {1'b0, mant} + (MAN_W + 2)'(up);
        // carry into bit MAN_W+1 bumps the exponent; no hidden bit means
        // the result stays subnormal and packs with exponent field 0
        exp_f = rnd[MAN_W+1] ? r2.exp + XW'(1) : (rnd[MAN_W] ? r2.exp : '0);

        res         = {r2.sign, exp_f[EXP_W-1:0], rnd[MAN_W-1:0]};
        flg         = '0;
        flg[FLG_NX] = nx;
        if (r2.spec) begin
            res = r2.spec_res;
            flg = r2.spec_flg;
        end else if (r2.zero) begin
            res = {r2.sign, {(W-1){1'b0}}};
            flg = '0;
        end else if (exp_f >= XW'(EMAX)) begin
            res         = {r2.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg[FLG_OF] = 1'b1;
            flg[FLG_NX] = 1'b1;
        end else if (r2.tiny) begin
`ifdef FP_ADDSUB_SUBNORMAL_EN
            flg[FLG_UF] = nx;
`else
            res         = {r2.sign, {(W-1){1'b0}}};
            flg[FLG_UF] = 1'b1;
            flg[FLG_NX] = 1'b1;
`endif
        end
    end

    // all stages advance together; a stalled output freezes the whole pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            r1       <= '0;
            r2       <= '0;
            result   <= '0;
            flags    <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            r1       <= s1_d;
            r2       <= s2_d;
            result   <= res;
            flags    <= flg;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe (fp32). Driver pushes expected
// results on accept; a monitor pops and compares on each output beat.
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [3:0]  flags;

    always #5 clk = ~clk;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          cyc;
        bit          lat;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // monitor: compare each emitted beat, and check holding while stalled
    initial begin
        logic [31:0] held_res;
        logic [3:0]  held_flg;
        bit          held;
        exp_t        e;
        held = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 0;
            end else if (out_valid) begin
                if (held) begin
                    check("hold_result", 64'(result), 64'(held_res));
                    check("hold_flags", 64'(flags), 64'(held_flg));
                end
                if (out_ready) begin
                    held = 0;
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_beat: got result %h with no beat outstanding", result);
                    end else begin
                        e = sb_q.pop_front();
                        check({e.name, "_result"}, 64'(result), 64'(e.res));
                        check({e.name, "_flags"}, 64'(flags), 64'(e.flg));
                        if (e.lat) check({e.name, "_latency"}, 64'(cyc - e.cyc), 64'(3));
                    end
                end else begin
                    held     = 1;
                    held_res = result;
                    held_flg = flags;
                end
            end else begin
                held = 0;
            end
        end
    end

    task automatic send(input string nm, input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, input logic [31:0] er, input logic [3:0] ef,
                        input bit push, input bit lat);
        bit   acc;
        int   n;
        exp_t e;
        acc = 0;
        n   = 0;
        a = ia; b = ib; sub = isub; in_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc   = in_ready && rst_n;
            e.cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL %s_accept: got no in_ready within 100 cycles", nm);
        end else if (push) begin
            e.res  = er;
            e.flg  = ef;
            e.lat  = lat;
            e.name = nm;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d beats outstanding want 0", sb_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_flags", 64'(flags), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // single beat, latency measured
        send("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 1, 1);
        drain();

        // back-to-back directed vectors
        send("tie_even_down", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 1, 0);
        send("tie_even_up",   32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 1, 0);
        send("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 1, 0);
        send("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 1, 0);
        send("cancel",        32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 1, 0);
        send("three_m_one",   32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 1, 0);
        send("one_m_1p5",     32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 4'b0000, 1, 0);
        send("neg_zeros",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 1, 0);
        send("mixed_zeros",   32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000, 1, 0);
        send("qnan_in",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 1, 0);
        send("snan_in",       32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 1, 0);
        send("neg_inf_pair",  32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, 1, 0);
        send("one_m_ulp",     32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'b0000, 1, 0);
        send("far_sticky",    32'h3F800000, 32'h0D800000, 1'b0, 32'h3F800000, 4'b0001, 1, 0);
`ifdef FP_ADDSUB_SUBNORMAL_EN
        send("sub_result",    32'h00800000, 32'h00400000, 1'b1, 32'h00400000, 4'b0000, 1, 0);
        send("tiny_exact",    32'h00C00000, 32'h00800000, 1'b1, 32'h00400000, 4'b0000, 1, 0);
`else
        send("sub_flushed",   32'h00800000, 32'h00400000, 1'b1, 32'h00800000, 4'b0000, 1, 0);
        send("tiny_flushed",  32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 1, 0);
`endif
        drain();

        // backpressure: consumer stalls 5 cycles once the pipe fills
        out_ready = 1'b0;
        fork
            begin
                send("bp0", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 1, 0);
                send("bp1", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000, 1, 0);
                send("bp2", 32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 4'b0000, 1, 0);
                send("bp3", 32'h41200000, 32'h3F800000, 1'b1, 32'h41100000, 4'b0000, 1, 0);
            end
            begin
                int n;
                n = 0;
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_pipe_filled", 64'(out_valid), 64'(1));
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 64'(in_ready), 64'(0));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // reset with three beats in flight: nothing may survive it
        out_ready = 1'b0;
        send("rst0", 32'h40000000, 32'h3F800000, 1'b0, 32'h0, 4'b0000, 0, 0);
        send("rst1", 32'h40400000, 32'h3F800000, 1'b0, 32'h0, 4'b0000, 0, 0);
        send("rst2", 32'h40800000, 32'h3F800000, 1'b0, 32'h0, 4'b0000, 0, 0);
        check("flight_out_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_result", 64'(result), 64'(0));
        check("midrst_flags", 64'(flags), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        repeat (8) @(posedge clk);
        #1;
        send("post_rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 1, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
